// File: rtl/mem_wb_stage_if.sv
// Data-memory handshake bus between the MEM/WB stage (master) and data memory (slave).
interface mem_wb_stage_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS memory-access / write-back stage: multi-cycle data-memory handshake with
// upstream freeze, access timeout, and the MEM/WB register driving register-file write-back.
module mem_wb_stage #(
  parameter int unsigned ADDR_BASE      = 1024,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] ST_Val,
  input  logic [4:0]  Dest,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        WB_EN,
  mem_wb_stage_if.master mem,
  output logic        Freeze,
  output logic [31:0] WB_Data,
  output logic [4:0]  WB_Dest,
  output logic        WB_Write_Enable,
  output logic        Mem_Error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        ld_data;
  logic               mem_op;
  logic               req;
  logic               timeout;

  assign mem_op = MEM_R_EN | MEM_W_EN;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          req       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          state_nxt = DONE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are forced low under reset and outside a request so every output reads 0 in reset.
  assign mem.mem_req   = req & ~rst;
  assign Freeze        = req & ~rst;
  assign mem.mem_we    = mem.mem_req & MEM_W_EN;
  assign mem.mem_addr  = mem.mem_req ? ADDR_W'((ALU_Result - ADDR_BASE) >> 2) : '0;
  assign mem.mem_wdata = mem.mem_req ? ST_Val : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      ld_data         <= '0;
      Mem_Error       <= 1'b0;
      WB_Data         <= '0;
      WB_Dest         <= '0;
      WB_Write_Enable <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == WAIT) cnt <= cnt + 1'b1;
      else               cnt <= '0;

      if (state == WAIT) begin
        if (mem.mem_ready) begin
          ld_data <= mem.mem_rdata;
        end else if (timeout) begin
          ld_data   <= '0;
          Mem_Error <= 1'b1;
        end
      end

      if (!Freeze) begin
        WB_Dest         <= Dest;
        WB_Data         <= MEM_R_EN ? ld_data : ALU_Result;
        WB_Write_Enable <= WB_EN & (Dest != 5'd0);
      end else begin
        WB_Write_Enable <= 1'b0;
      end
    end
  end

endmodule
